amba_apb_read_slave: RTL and testbench

- APB-style read-only slave front end that returns a 32-bit register value to the bus master on a read transfer.
- Sits between the APB interconnect and the sensor-fusion register bank; `RegisterData` is the live register contents.
- PADDR acts as a per-bit lane-select mask on the returned data.
- Provides programmable wait states and a transfer timeout reported on PSLVERR.

---
 rtl/amba_apb_read_slave.sv | 140 ++++++++++++++
 tb/tb_amba_apb_read_slave.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/amba_apb_read_slave.sv
// APB read-only slave front end: masked register read, wait states, timeout.
// Optional timeout counter enabled by `define AMBA_READ_TIMEOUT_EN.
module amba_apb_read_slave #(
  parameter int WAIT_STATES    = 0,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] RegisterData,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_wait;
  logic [31:0]      r_prdata;
  logic             r_pready;
  logic             r_pslverr;

  logic [1:0] w_nxt;
  logic       w_ok;
  logic       w_err;
  logic       w_clr;
  logic       w_wait_done;
  logic       w_tmo_hit;

  assign w_wait_done = (r_wait == CNT_W'(WAIT_STATES));

`ifdef AMBA_READ_TIMEOUT_EN
  logic [CNT_W-1:0] r_tmo;

  // Counts every cycle spent in SETUP or ACCESS of the current transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET || w_clr) begin
      r_tmo <= '0;
    end else if (r_state == S_SETUP || r_state == S_ACCESS) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // Hit on the last allowed cycle so the error lands after TIMEOUT_CYCLES.
  assign w_tmo_hit = (r_tmo == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next state and response selection; master aborts beat timeout, timeout beats completion.
  always_comb begin
    w_nxt = r_state;
    w_ok  = 1'b0;
    w_err = 1'b0;
    w_clr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!PWRITE) begin
          if (PENABLE) begin
            w_err = 1'b1;
            w_nxt = S_HOLD;
          end else begin
            w_clr = 1'b1;
            w_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (PWRITE) begin
          w_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_err = 1'b1;
          w_nxt = S_HOLD;
        end else if (PENABLE) begin
          w_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (PWRITE || !PENABLE) begin
          w_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_err = 1'b1;
          w_nxt = S_HOLD;
        end else if (w_wait_done) begin
          w_ok  = 1'b1;
          w_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PWRITE) begin
          w_nxt = S_IDLE;
        end else if (!PENABLE) begin
          w_clr = 1'b1;
          w_nxt = S_SETUP;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Wait counter advances only while in ACCESS; cleared on each new transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET || w_clr) begin
      r_wait <= '0;
    end else if (r_state == S_ACCESS) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // State and registered outputs; PREADY/PSLVERR are one-cycle pulses.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_pready  <= w_ok | w_err;
      r_pslverr <= w_err;
      if (w_ok) begin
        r_prdata <= RegisterData & PADDR;
      end else if (w_err) begin
        r_prdata <= '0;
      end
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_amba_apb_read_slave.sv
// Bench for amba_apb_read_slave: vector table, corner sequences, random vs model.
// Three instances with different wait/timeout settings share one stimulus.
module tb_amba_apb_read_slave;

`ifdef AMBA_READ_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        pw;
  logic        pe;
  logic [31:0] data;

  logic [31:0] o_rd  [3];
  logic        o_rdy [3];
  logic        o_err [3];

  int checks = 0;
  int errors = 0;

  int WSv [3] = '{0, 3, 1};
  int TOv [3] = '{16, 16, 4};

  int          m_ph  [3];
  int          m_age [3];
  int          m_acc [3];
  logic [31:0] m_rd  [3];
  logic        m_rdy [3];
  logic        m_err [3];

  always #5 clk = ~clk;

  amba_apb_read_slave #(.WAIT_STATES(0), .TIMEOUT_CYCLES(16), .CNT_W(8)) u0 (
    .PCLK(clk), .PRESET(rst), .PADDR(addr), .PWRITE(pw), .PENABLE(pe),
    .RegisterData(data), .PRDATA(o_rd[0]), .PREADY(o_rdy[0]),
    .PSLVERR(o_err[0]));

  amba_apb_read_slave #(.WAIT_STATES(3), .TIMEOUT_CYCLES(16), .CNT_W(8)) u1 (
    .PCLK(clk), .PRESET(rst), .PADDR(addr), .PWRITE(pw), .PENABLE(pe),
    .RegisterData(data), .PRDATA(o_rd[1]), .PREADY(o_rdy[1]),
    .PSLVERR(o_err[1]));

  amba_apb_read_slave #(.WAIT_STATES(1), .TIMEOUT_CYCLES(4), .CNT_W(8)) u2 (
    .PCLK(clk), .PRESET(rst), .PADDR(addr), .PWRITE(pw), .PENABLE(pe),
    .RegisterData(data), .PRDATA(o_rd[2]), .PREADY(o_rdy[2]),
    .PSLVERR(o_err[2]));

  typedef struct {
    logic        rst;
    logic        pw;
    logic        pe;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] erd;
    logic        erdy;
    logic        eerr;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic w, input logic e,
                        input logic [31:0] a, input logic [31:0] d);
    rst = r; pw = w; pe = e; addr = a; data = d;
  endtask

  // Transfer-level model: counts cycles in the transfer and in the access phase.
  task automatic model_step(input int k);
    if (rst) begin
      m_ph[k] = 0; m_age[k] = 0; m_acc[k] = 0;
      m_rd[k] = '0; m_rdy[k] = 1'b0; m_err[k] = 1'b0;
    end else begin
      m_rdy[k] = 1'b0;
      m_err[k] = 1'b0;
      case (m_ph[k])
        0: begin
          if (!pw && pe) begin
            m_rd[k] = '0; m_rdy[k] = 1'b1; m_err[k] = 1'b1; m_ph[k] = 3;
          end else if (!pw) begin
            m_ph[k] = 1; m_age[k] = 0; m_acc[k] = 0;
          end
        end
        1, 2: begin
          if (pw || (m_ph[k] == 2 && !pe)) begin
            m_ph[k] = 0;
          end else begin
            m_age[k]++;
            if (TEN && m_age[k] == TOv[k]) begin
              m_rd[k] = '0; m_rdy[k] = 1'b1; m_err[k] = 1'b1; m_ph[k] = 3;
            end else if (m_ph[k] == 1) begin
              if (pe) m_ph[k] = 2;
            end else begin
              m_acc[k]++;
              if (m_acc[k] == WSv[k] + 1) begin
                m_rd[k] = data & addr; m_rdy[k] = 1'b1; m_ph[k] = 3;
              end
            end
          end
        end
        default: begin
          if (pw) begin
            m_ph[k] = 0;
          end else if (!pe) begin
            m_ph[k] = 1; m_age[k] = 0; m_acc[k] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.PRDATA", k), o_rd[k], m_rd[k]);
      chk($sformatf("u%0d.PREADY", k), 32'(o_rdy[k]), 32'(m_rdy[k]));
      chk($sformatf("u%0d.PSLVERR", k), 32'(o_err[k]), 32'(m_err[k]));
    end
  endtask

  function automatic vec_t mk(logic r, logic w, logic e, logic [31:0] a,
                              logic [31:0] d, logic [31:0] erd, logic erdy,
                              logic eerr);
    vec_t v;
    v.rst = r; v.pw = w; v.pe = e; v.addr = a; v.data = d;
    v.erd = erd; v.erdy = erdy; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    int lat;
    for (int k = 0; k < 3; k++) begin
      m_ph[k] = 0; m_age[k] = 0; m_acc[k] = 0;
      m_rd[k] = '0; m_rdy[k] = 1'b0; m_err[k] = 1'b0;
    end
    set_in(1'b1, 1'b1, 1'b0, '0, '0);

    vt[0]  = mk(1, 1, 0, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0, 0, 0);
    vt[1]  = mk(1, 1, 0, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0, 0, 0);
    vt[2]  = mk(0, 0, 0, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0, 0, 0);
    vt[3]  = mk(0, 0, 0, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0, 0, 0);
    vt[4]  = mk(0, 0, 1, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0, 0, 0);
    vt[5]  = mk(0, 0, 1, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFF0000, 1, 0);
    vt[6]  = mk(0, 1, 0, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFF0000, 0, 0);
    vt[7]  = mk(0, 1, 0, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFF0000, 0, 0);
    vt[8]  = mk(0, 0, 0, 32'h00FF00FF, 32'hFFFF0000, 32'hFFFF0000, 0, 0);
    vt[9]  = mk(0, 0, 1, 32'h00FF00FF, 32'hFFFF0000, 32'hFFFF0000, 0, 0);
    vt[10] = mk(0, 0, 1, 32'h00FF00FF, 32'hFFFF0000, 32'h00FF0000, 1, 0);
    vt[11] = mk(0, 0, 1, 32'h00FF00FF, 32'h12345678, 32'h00FF0000, 0, 0);
    vt[12] = mk(0, 1, 0, 32'h00FF00FF, 32'h12345678, 32'h00FF0000, 0, 0);
    vt[13] = mk(0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 1);
    vt[14] = mk(0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0);
    vt[15] = mk(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      set_in(vt[i].rst, vt[i].pw, vt[i].pe, vt[i].addr, vt[i].data);
      tick();
      chk($sformatf("vec%0d.PRDATA", i), o_rd[0], vt[i].erd);
      chk($sformatf("vec%0d.PREADY", i), 32'(o_rdy[0]), 32'(vt[i].erdy));
      chk($sformatf("vec%0d.PSLVERR", i), 32'(o_err[0]), 32'(vt[i].eerr));
    end

    set_in(1, 1, 0, 32'hFFFFFFFF, 32'hFFFF0000); tick();
    set_in(0, 0, 0, 32'hFFFFFFFF, 32'hFFFF0000); tick();
    pe = 1'b1; tick();
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (o_rdy[1] && lat < 0) lat = n;
    end
    chk("ws3_latency", 32'(lat), 32'd4);

    set_in(1, 1, 0, 32'hFFFFFFFF, 32'hA5A5A5A5); tick();
    set_in(0, 0, 0, 32'hFFFFFFFF, 32'hA5A5A5A5); tick();
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (o_rdy[2] && lat < 0) lat = n;
    end
    if (TEN) chk("timeout_latency", 32'(lat), 32'd4);
    else chk("no_timeout", 32'(lat), 32'hFFFFFFFF);

    set_in(1, 1, 0, 32'hFFFFFFFF, 32'hFFFF0000); tick();
    set_in(0, 0, 0, 32'hFFFFFFFF, 32'hFFFF0000); tick();
    pe = 1'b1; tick();
    tick();
    rst = 1'b1; tick();
    chk("midrst_PREADY", 32'(o_rdy[1]), 32'd0);
    chk("midrst_PRDATA", o_rd[1], 32'd0);
    rst = 1'b0; tick();
    chk("midrst_idle_proto_err", 32'(o_err[1]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(63) == 0);
      pw   = ($urandom_range(7) == 0);
      pe   = ($urandom_range(3) != 0);
      addr = $urandom;
      data = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
